// File: rtl/ittage_pkg.sv
// Shared types, widths and the history insertion function for the ITTAGE
// path-history context generator. All widths of the block are set here.
package ittage_pkg;

   localparam int PLEN           = 32;
   localparam int ILEN           = 32;
   localparam int PATH_HIST_BITS = 16;
   localparam int HIST_SHIFT     = 2;
   localparam int CKPT_DEPTH     = 16;

   localparam int CKPT_ID_W      = $clog2(CKPT_DEPTH);
   localparam int INSTR_ADDR_LSB = $clog2(ILEN/8);
   localparam int FOLD_BITS      = PLEN - INSTR_ADDR_LSB;
   localparam int FOLD_CHUNKS    = (FOLD_BITS + PATH_HIST_BITS - 1) / PATH_HIST_BITS;

   typedef logic [PATH_HIST_BITS-1:0] phist_t;
   typedef logic [CKPT_ID_W-1:0]      ckpt_id_t;
   typedef logic [CKPT_ID_W:0]        ckpt_cnt_t;
   typedef logic [PLEN-1:0]           addr_t;

   // Shift the history and XOR in the folded target (low alignment bits dropped,
   // last chunk zero-padded).
   function automatic phist_t phist_ins(input phist_t h, input addr_t t);
      logic [FOLD_CHUNKS*PATH_HIST_BITS-1:0] pad;
      phist_t                                f;
      pad = '0;
      pad[FOLD_BITS-1:0] = t[PLEN-1:INSTR_ADDR_LSB];
      f = '0;
      for (int i = 0; i < FOLD_CHUNKS; i++) begin
         f = f ^ pad[i*PATH_HIST_BITS +: PATH_HIST_BITS];
      end
      return phist_t'(h << HIST_SHIFT) ^ f;
   endfunction

endpackage

// File: rtl/ittage_phist_fold.sv
// Combinational fold of a target into a path history (shift then XOR).
module ittage_phist_fold
   import ittage_pkg::*;
(
   input  logic [PATH_HIST_BITS-1:0] hist,
   input  logic [PLEN-1:0]           target,
   output logic [PATH_HIST_BITS-1:0] hist_next
);

   assign hist_next = phist_ins(hist, target);

endmodule

// File: rtl/ittage_path_hist.sv
// Speculative path history for the ITTAGE predictor, checkpointed per fetch
// block in a ring buffer, restored on mispredict, plus the registered ITTAGE
// training update.
// Optional: define ITTAGE_PHIST_STATS_EN to add flush / full-stall counters.
module ittage_path_hist
   import ittage_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   output logic [PATH_HIST_BITS-1:0] predict_ctx_o,
   input  logic                      alloc_valid_i,
   output logic                      alloc_ready_o,
   input  logic                      alloc_taken_i,
   input  logic [PLEN-1:0]           alloc_target_i,
   output logic [CKPT_ID_W-1:0]      alloc_id_o,
   input  logic                      resolve_valid_i,
   input  logic [CKPT_ID_W-1:0]      resolve_id_i,
   input  logic                      resolve_mispredict_i,
   input  logic                      resolve_taken_i,
   input  logic                      resolve_indirect_i,
   input  logic [PLEN-1:0]           resolve_pc_i,
   input  logic [PLEN-1:0]           resolve_target_i,
   input  logic                      commit_valid_i,
`ifdef ITTAGE_PHIST_STATS_EN
   output logic [31:0]               stat_flush_cnt_o,
   output logic [31:0]               stat_full_cnt_o,
`endif
   output logic                      update_valid_o,
   output logic [PLEN-1:0]           update_pc_o,
   output logic [PATH_HIST_BITS-1:0] update_ctx_o,
   output logic [PLEN-1:0]           update_target_o
);

   localparam ckpt_cnt_t CNT_FULL = ckpt_cnt_t'(CKPT_DEPTH);

   phist_t    hist_q;
   phist_t    ckpt_q [CKPT_DEPTH];
   ckpt_id_t  head_q;
   ckpt_id_t  tail_q;
   ckpt_cnt_t count_q;

   logic      flush;
   logic      full;
   logic      alloc_fire;
   logic      commit_fire;
   logic      train;
   phist_t    restore_base;
   phist_t    hist_alloc_ins;
   phist_t    hist_restore_ins;
   ckpt_id_t  flush_span;

   assign flush         = resolve_valid_i & resolve_mispredict_i;
   assign full          = (count_q == CNT_FULL);
   assign alloc_ready_o = !full & !flush;
   assign alloc_fire    = alloc_valid_i & alloc_ready_o;
   assign commit_fire   = commit_valid_i & (count_q != '0);
   assign train         = resolve_valid_i & resolve_indirect_i & resolve_taken_i;
   assign restore_base  = ckpt_q[resolve_id_i];
   assign flush_span    = resolve_id_i - head_q;

   assign predict_ctx_o = hist_q;
   assign alloc_id_o    = tail_q;

   ittage_phist_fold u_fold_alloc (
      .hist      (hist_q),
      .target    (alloc_target_i),
      .hist_next (hist_alloc_ins)
   );

   ittage_phist_fold u_fold_restore (
      .hist      (restore_base),
      .target    (resolve_target_i),
      .hist_next (hist_restore_ins)
   );

   // Checkpoint storage: snapshot the pre-insertion history on each accepted alloc.
   always_ff @(posedge clk_i) begin
      if (alloc_fire) begin
         ckpt_q[tail_q] <= hist_q;
      end
   end

   // History, ring pointers and occupancy; a flush rewinds tail to just past the resolved slot.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         hist_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q <= head_q + ckpt_id_t'(commit_fire);
         if (flush) begin
            hist_q  <= resolve_taken_i ? hist_restore_ins : restore_base;
            tail_q  <= resolve_id_i + ckpt_id_t'(1);
            count_q <= ckpt_cnt_t'(flush_span) + ckpt_cnt_t'(1) - ckpt_cnt_t'(commit_fire);
         end else begin
            if (alloc_fire) begin
               hist_q <= alloc_taken_i ? hist_alloc_ins : hist_q;
               tail_q <= tail_q + ckpt_id_t'(1);
            end
            count_q <= count_q + ckpt_cnt_t'(alloc_fire) - ckpt_cnt_t'(commit_fire);
         end
      end
   end

   // Registered ITTAGE training update; data holds when no update is issued.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         update_valid_o  <= 1'b0;
         update_pc_o     <= '0;
         update_ctx_o    <= '0;
         update_target_o <= '0;
      end else begin
         update_valid_o <= train;
         if (train) begin
            update_pc_o     <= resolve_pc_i;
            update_ctx_o    <= restore_base;
            update_target_o <= resolve_target_i;
         end
      end
   end

`ifdef ITTAGE_PHIST_STATS_EN
   // Event counters: mispredict flushes and cycles an alloc was offered while full.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stat_flush_cnt_o <= '0;
         stat_full_cnt_o  <= '0;
      end else begin
         stat_flush_cnt_o <= stat_flush_cnt_o + 32'(flush);
         stat_full_cnt_o  <= stat_full_cnt_o + 32'(alloc_valid_i & full);
      end
   end
`endif

endmodule

// File: tb/tb_ittage_path_hist.sv
// Directed vector bench for ittage_path_hist (PLEN=32, 16-bit history, depth 16).
module tb_ittage_path_hist;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [15:0] predict_ctx_o;
   logic        alloc_valid_i;
   logic        alloc_ready_o;
   logic        alloc_taken_i;
   logic [31:0] alloc_target_i;
   logic [3:0]  alloc_id_o;
   logic        resolve_valid_i;
   logic [3:0]  resolve_id_i;
   logic        resolve_mispredict_i;
   logic        resolve_taken_i;
   logic        resolve_indirect_i;
   logic [31:0] resolve_pc_i;
   logic [31:0] resolve_target_i;
   logic        commit_valid_i;
   logic        update_valid_o;
   logic [31:0] update_pc_o;
   logic [15:0] update_ctx_o;
   logic [31:0] update_target_o;
`ifdef ITTAGE_PHIST_STATS_EN
   logic [31:0] stat_flush_cnt_o;
   logic [31:0] stat_full_cnt_o;
`endif

   ittage_path_hist dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .predict_ctx_o        (predict_ctx_o),
      .alloc_valid_i        (alloc_valid_i),
      .alloc_ready_o        (alloc_ready_o),
      .alloc_taken_i        (alloc_taken_i),
      .alloc_target_i       (alloc_target_i),
      .alloc_id_o           (alloc_id_o),
      .resolve_valid_i      (resolve_valid_i),
      .resolve_id_i         (resolve_id_i),
      .resolve_mispredict_i (resolve_mispredict_i),
      .resolve_taken_i      (resolve_taken_i),
      .resolve_indirect_i   (resolve_indirect_i),
      .resolve_pc_i         (resolve_pc_i),
      .resolve_target_i     (resolve_target_i),
      .commit_valid_i       (commit_valid_i),
`ifdef ITTAGE_PHIST_STATS_EN
      .stat_flush_cnt_o     (stat_flush_cnt_o),
      .stat_full_cnt_o      (stat_full_cnt_o),
`endif
      .update_valid_o       (update_valid_o),
      .update_pc_o          (update_pc_o),
      .update_ctx_o         (update_ctx_o),
      .update_target_o      (update_target_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        av;
      logic        at;
      logic [31:0] atgt;
      logic        rv;
      logic [3:0]  rid;
      logic        rm;
      logic        rt;
      logic        ri;
      logic [31:0] rpc;
      logic [31:0] rtgt;
      logic        cm;
   } stim_t;

   typedef struct {
      stim_t       s;
      logic [3:0]  e_id;
      logic        e_rdy;
      logic [15:0] e_ctx;
      logic        e_uv;
      logic [15:0] e_uctx;
      logic [31:0] e_upc;
      logic [31:0] e_utgt;
   } vec_t;

   int total = 0;
   int bad   = 0;

   localparam int NV = 10;
   vec_t vecs [NV];

   function automatic stim_t st(input logic av, input logic at, input logic [31:0] atgt,
                                input logic rv, input logic [3:0] rid, input logic rm,
                                input logic rt, input logic ri, input logic [31:0] rpc,
                                input logic [31:0] rtgt, input logic cm);
      stim_t s;
      s.av = av; s.at = at; s.atgt = atgt; s.rv = rv; s.rid = rid; s.rm = rm;
      s.rt = rt; s.ri = ri; s.rpc = rpc; s.rtgt = rtgt; s.cm = cm;
      return s;
   endfunction

   function automatic vec_t mk(input stim_t s, input logic [3:0] id, input logic rdy,
                               input logic [15:0] ctx, input logic uv, input logic [15:0] uctx,
                               input logic [31:0] upc, input logic [31:0] utgt);
      vec_t v;
      v.s = s; v.e_id = id; v.e_rdy = rdy; v.e_ctx = ctx; v.e_uv = uv;
      v.e_uctx = uctx; v.e_upc = upc; v.e_utgt = utgt;
      return v;
   endfunction

   function automatic stim_t idle();
      return st(0, 0, 32'h0, 0, 4'h0, 0, 0, 0, 32'h0, 32'h0, 0);
   endfunction

   function automatic stim_t alloc(input logic taken, input logic [31:0] tgt, input logic cm);
      return st(1, taken, tgt, 0, 4'h0, 0, 0, 0, 32'h0, 32'h0, cm);
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   // Drive a cycle's inputs on the falling edge; combinational outputs settle by +1.
   task automatic drive(input stim_t s);
      @(negedge clk_i);
      alloc_valid_i        = s.av;
      alloc_taken_i        = s.at;
      alloc_target_i       = s.atgt;
      resolve_valid_i      = s.rv;
      resolve_id_i         = s.rid;
      resolve_mispredict_i = s.rm;
      resolve_taken_i      = s.rt;
      resolve_indirect_i   = s.ri;
      resolve_pc_i         = s.rpc;
      resolve_target_i     = s.rtgt;
      commit_valid_i       = s.cm;
      #1;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      drive(idle());
      rst_ni = 1'b0;
      tick();
      drive(idle());
      rst_ni = 1'b1;
   endtask

   // From empty: exactly 16 allocs fit, ids 0..15, then ready drops.
   task automatic fill16(input string tag);
      for (int i = 0; i < 16; i++) begin
         drive(alloc(0, 32'h0, 0));
         chk($sformatf("%s_rdy%0d", tag, i), 32'(alloc_ready_o), 32'd1);
         chk($sformatf("%s_id%0d", tag, i), 32'(alloc_id_o), 32'(i));
         tick();
      end
      drive(idle());
      chk($sformatf("%s_full_rdy", tag), 32'(alloc_ready_o), 32'd0);
   endtask

   initial begin
      rst_ni = 1'b0;
      drive(idle());
      tick();
      tick();
      chk("rst_ctx", 32'(predict_ctx_o), 32'h0);
      chk("rst_uv", 32'(update_valid_o), 32'h0);
      chk("rst_upc", update_pc_o, 32'h0);
      chk("rst_uctx", 32'(update_ctx_o), 32'h0);
      chk("rst_utgt", update_target_o, 32'h0);
      chk("rst_id", 32'(alloc_id_o), 32'h0);
      chk("rst_rdy", 32'(alloc_ready_o), 32'h1);
`ifdef ITTAGE_PHIST_STATS_EN
      chk("rst_stat_flush", stat_flush_cnt_o, 32'h0);
      chk("rst_stat_full", stat_full_cnt_o, 32'h0);
`endif
      drive(idle());
      rst_ni = 1'b1;

      // id/rdy checked before the edge, the rest after it
      vecs[0] = mk(alloc(1, 32'h8000_0010, 0),
                   4'd0, 1, 16'h2004, 0, 16'h0000, 32'h0, 32'h0);
      vecs[1] = mk(alloc(1, 32'h8000_0020, 0),
                   4'd1, 1, 16'hA018, 0, 16'h0000, 32'h0, 32'h0);
      vecs[2] = mk(st(0, 0, 32'h0, 1, 4'd1, 0, 1, 1, 32'h8000_0100, 32'h8000_0400, 0),
                   4'd2, 1, 16'hA018, 1, 16'h2004, 32'h8000_0100, 32'h8000_0400);
      vecs[3] = mk(idle(),
                   4'd2, 1, 16'hA018, 0, 16'h2004, 32'h8000_0100, 32'h8000_0400);
      vecs[4] = mk(st(1, 1, 32'h1234_5678, 1, 4'd0, 1, 0, 0, 32'h0000_DEAD, 32'h0000_BEEF, 0),
                   4'd2, 0, 16'h0000, 0, 16'h2004, 32'h8000_0100, 32'h8000_0400);
      vecs[5] = mk(alloc(0, 32'h5555_5550, 0),
                   4'd1, 1, 16'h0000, 0, 16'h2004, 32'h8000_0100, 32'h8000_0400);
      vecs[6] = mk(st(0, 0, 32'h0, 1, 4'd1, 1, 1, 1, 32'h8000_0200, 32'h8000_0010, 0),
                   4'd2, 0, 16'h2004, 1, 16'h0000, 32'h8000_0200, 32'h8000_0010);
      vecs[7] = mk(alloc(1, 32'h8000_0020, 1),
                   4'd2, 1, 16'hA018, 0, 16'h0000, 32'h8000_0200, 32'h8000_0010);
      vecs[8] = mk(st(0, 0, 32'h0, 1, 4'd2, 1, 0, 0, 32'h0, 32'h0, 1),
                   4'd3, 0, 16'h2004, 0, 16'h0000, 32'h8000_0200, 32'h8000_0010);
      vecs[9] = mk(alloc(0, 32'h0, 0),
                   4'd3, 1, 16'h2004, 0, 16'h0000, 32'h8000_0200, 32'h8000_0010);

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i].s);
         chk($sformatf("v%0d_id", i), 32'(alloc_id_o), 32'(vecs[i].e_id));
         chk($sformatf("v%0d_rdy", i), 32'(alloc_ready_o), 32'(vecs[i].e_rdy));
         tick();
         chk($sformatf("v%0d_ctx", i), 32'(predict_ctx_o), 32'(vecs[i].e_ctx));
         chk($sformatf("v%0d_uv", i), 32'(update_valid_o), 32'(vecs[i].e_uv));
         chk($sformatf("v%0d_uctx", i), 32'(update_ctx_o), 32'(vecs[i].e_uctx));
         chk($sformatf("v%0d_upc", i), update_pc_o, vecs[i].e_upc);
         chk($sformatf("v%0d_utgt", i), update_target_o, vecs[i].e_utgt);
      end
`ifdef ITTAGE_PHIST_STATS_EN
      chk("stat_flush_3", stat_flush_cnt_o, 32'd3);
      chk("stat_full_0", stat_full_cnt_o, 32'd0);
`endif

      // Full ring, refused alloc, commit at empty ignored, alloc+commit keeps count
      do_reset();
      drive(st(0, 0, 32'h0, 0, 4'h0, 0, 0, 0, 32'h0, 32'h0, 1));
      tick();
      fill16("t3");
      drive(alloc(0, 32'h0, 0));
      chk("t3_17th_rdy", 32'(alloc_ready_o), 32'd0);
      tick();
      drive(idle());
      chk("t3_17th_id", 32'(alloc_id_o), 32'd0);
      chk("t3_17th_still_full", 32'(alloc_ready_o), 32'd0);
`ifdef ITTAGE_PHIST_STATS_EN
      chk("t3_stat_full", stat_full_cnt_o, 32'd1);
`endif
      drive(st(0, 0, 32'h0, 0, 4'h0, 0, 0, 0, 32'h0, 32'h0, 1));
      tick();
      drive(idle());
      chk("t3_commit_rdy", 32'(alloc_ready_o), 32'd1);
      drive(alloc(0, 32'h0, 1));
      chk("t3_ac_id", 32'(alloc_id_o), 32'd0);
      tick();
      drive(idle());
      chk("t3_ac_rdy", 32'(alloc_ready_o), 32'd1);
      chk("t3_ac_id_next", 32'(alloc_id_o), 32'd1);
      drive(alloc(0, 32'h0, 0));
      tick();
      drive(idle());
      chk("t3_refull_rdy", 32'(alloc_ready_o), 32'd0);

      // Tail wrap over 20 alloc/commit pairs, then flush racing an alloc
      do_reset();
      drive(alloc(0, 32'h0, 0));
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(alloc(0, 32'h0, 1));
         chk($sformatf("t5_wrap_id%0d", i), 32'(alloc_id_o), 32'((i + 1) % 16));
         chk($sformatf("t5_wrap_rdy%0d", i), 32'(alloc_ready_o), 32'd1);
         tick();
      end
      drive(st(1, 1, 32'h0000_1000, 1, 4'd4, 1, 1, 0, 32'h0, 32'h8000_0010, 0));
      chk("t5_flush_rdy", 32'(alloc_ready_o), 32'd0);
      tick();
      chk("t5_flush_ctx", 32'(predict_ctx_o), 32'h2004);
      drive(idle());
      chk("t5_flush_tail", 32'(alloc_id_o), 32'd5);

      // Mid-stream reset while a training resolve is presented
      drive(alloc(1, 32'h8000_0010, 0));
      tick();
      drive(st(0, 0, 32'h0, 1, 4'd5, 0, 1, 1, 32'h8000_0300, 32'h8000_0500, 0));
      rst_ni = 1'b0;
      tick();
      chk("t6_ctx", 32'(predict_ctx_o), 32'h0);
      chk("t6_uv", 32'(update_valid_o), 32'h0);
      chk("t6_upc", update_pc_o, 32'h0);
      chk("t6_id", 32'(alloc_id_o), 32'h0);
`ifdef ITTAGE_PHIST_STATS_EN
      chk("t6_stat_flush", stat_flush_cnt_o, 32'h0);
      chk("t6_stat_full", stat_full_cnt_o, 32'h0);
`endif
      drive(idle());
      rst_ni = 1'b1;
      fill16("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
